div_unit: RTL and testbench

- Sequential unsigned restoring divider for the FFT datapath; the inverse of the 16x16 -> 32 multiplier unit.
- Takes a 32-bit dividend (product-width) and a 16-bit divisor; returns a 32-bit quotient and a 16-bit remainder.
- Uses a valid/ready handshake on both sides.
- Used for normalisation/scaling and for checking multiplier round-trips: (a*b)/b = a.

---
 rtl/fft_arith_pkg.sv | 17 +
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 124 ++++++++++++
 tb/tb_div_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_arith_pkg.sv
// rtl/fft_arith_pkg.sv - shared widths and divider state type for the FFT arithmetic units
package fft_arith_pkg;

  // operand width of the multiplier / remainder width of the divider
  localparam int DATA_W = 16;
  // product width of the multiplier / dividend and quotient width of the divider
  localparam int PROD_W = 32;
  // step counter must hold the value PROD_W itself
  localparam int DIV_CNT_W = $clog2(PROD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring division step: shift in a bit, trial-subtract, restore
module div_step
  import fft_arith_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] pr,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] pr_next,
  output logic         q_bit
);

  logic [W:0] trial;
  logic [W:0] diff;

  // The incoming partial remainder is always < divisor, so trial < 2*divisor.
  // On success the difference fits in W bits; on failure the W+1-bit
  // subtraction wraps and always sets diff[W], which therefore acts as the borrow.
  assign trial   = {pr, bit_in};
  assign diff    = trial - {1'b0, divisor};
  assign q_bit   = ~diff[W];
  assign pr_next = q_bit ? diff[W-1:0] : trial[W-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential unsigned restoring divider with valid/ready handshakes
module div_unit
  import fft_arith_pkg::*;
#(
  parameter int DIVIDEND_W = PROD_W,
  parameter int DIVISOR_W  = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  q_ovf
);

  // sized from the actual dividend width so non-default parameters still count correctly
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  div_state_t state, state_next;

  logic [DIVIDEND_W-1:0] qreg;
  logic [DIVIDEND_W-1:0] q_shift;
  logic [DIVISOR_W-1:0]  pr;
  logic [DIVISOR_W-1:0]  pr_next;
  logic [DIVISOR_W-1:0]  dsr;
  logic [CNT_W-1:0]      cnt;
  logic                  q_bit;
  logic                  dbz_r;
  logic                  ovf_r;
  logic                  accept;

  assign accept  = in_valid && in_ready;
  assign q_shift = {qreg[DIVIDEND_W-2:0], q_bit};

  div_step #(.W(DIVISOR_W)) u_step (
    .pr      (pr),
    .bit_in  (qreg[DIVIDEND_W-1]),
    .divisor (dsr),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next-state: zero divisor skips CALC, DONE waits for the consumer
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // handshake outputs, both held low while reset is asserted
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    in_ready  = 1'b1;
        DONE:    out_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // datapath: quotient/shift register doubles as the dividend, flags settle on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      qreg  <= '0;
      pr    <= '0;
      dsr   <= '0;
      cnt   <= '0;
      dbz_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dsr <= divisor;
            if (divisor == '0) begin
              qreg  <= '1;
              pr    <= dividend[DIVISOR_W-1:0];
              cnt   <= '0;
              dbz_r <= 1'b1;
              ovf_r <= 1'b1;
            end else begin
              qreg  <= dividend;
              pr    <= '0;
              cnt   <= CNT_W'(DIVIDEND_W);
              dbz_r <= 1'b0;
              ovf_r <= 1'b0;
            end
          end
        end
        CALC: begin
          qreg <= q_shift;
          pr   <= pr_next;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) ovf_r <= |(q_shift >> DIVISOR_W);
        end
        default: ;
      endcase
    end
  end

  assign quotient    = qreg;
  assign remainder   = pr;
  assign div_by_zero = dbz_r;
  assign q_ovf       = ovf_r;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit with a scoreboard queue
module tb_div_unit;
  import fft_arith_pkg::*;

  localparam int DW = PROD_W;
  localparam int SW = DATA_W;

  typedef struct {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dbz;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [SW-1:0] divisor = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;
  logic          q_ovf;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .q_ovf       (q_ovf)
  );

  function automatic exp_t model(input logic [DW-1:0] dd, input logic [SW-1:0] ds);
    exp_t e;
    if (ds == '0) begin
      e.q   = '1;
      e.r   = dd[SW-1:0];
      e.dbz = 1'b1;
      e.ovf = 1'b1;
    end else begin
      e.q   = dd / {{(DW-SW){1'b0}}, ds};
      e.r   = SW'(dd % {{(DW-SW){1'b0}}, ds});
      e.dbz = 1'b0;
      e.ovf = (e.q >> SW) != '0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [DW-1:0] dd, input logic [SW-1:0] ds);
    check("accept_in_ready", in_ready, 1);
    sb.push_back(model(dd, ds));
    in_valid = 1'b1;
    dividend = dd;
    divisor  = ds;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat);
    int n = 1;
    while (out_valid !== 1'b1 && n <= DW + 5) begin
      dividend = $urandom;
      divisor  = SW'($urandom);
      tick();
      n++;
    end
    check("latency", n, exp_lat);
  endtask

  task automatic collect();
    exp_t e;
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("out_valid", out_valid, 1);
      check("quotient", quotient, e.q);
      check("remainder", remainder, e.r);
      check("div_by_zero", div_by_zero, e.dbz);
      check("q_ovf", q_ovf, e.ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
  endtask

  task automatic run(input logic [DW-1:0] dd, input logic [SW-1:0] ds, input int lat);
    start_op(dd, ds);
    wait_out(lat);
    collect();
  endtask

  initial begin
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    logic [DW-1:0] p;

    // reset state
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_ovf", q_ovf, 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // directed cases
    start_op(32'h000F4240, 16'h03E8);
    wait_out(33);
    check("k_1e6_q", quotient, 32'h000003E8);
    check("k_1e6_r", remainder, 0);
    collect();
    start_op(32'hFFFFFFFF, 16'hFFFF);
    wait_out(33);
    check("k_max_q", quotient, 32'h00010001);
    check("k_max_ovf", q_ovf, 1);
    collect();
    start_op(32'h12345678, 16'h0000);
    wait_out(1);
    check("k_dbz_r", remainder, 16'h5678);
    collect();
    run(32'hFFFFFFFF, 16'h0001, 33);
    run(32'h00000000, 16'h0005, 33);
    run(32'hFFFE0001, 16'hFFFF, 33);
    run(32'h0000FFFF, 16'h0001, 33);

    // hold result while consumer stalls and a new op waits
    start_op(32'd7, 16'd10);
    wait_out(33);
    in_valid = 1'b1;
    dividend = 32'd50;
    divisor  = 16'd7;
    out_ready = 1'b0;
    repeat (5) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_quotient", quotient, 0);
      check("hold_remainder", remainder, 7);
      tick();
    end
    collect();
    start_op(32'd50, 16'd7);
    wait_out(33);
    collect();

    // reset in the middle of CALC drops the operation
    start_op(32'd100, 16'd3);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    void'(sb.pop_back());
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    tick();
    check("midrst_in_ready2", in_ready, 0);
    rst = 1'b0;
    tick();
    check("after_rst_out_valid", out_valid, 0);
    start_op(32'd100, 16'd3);
    wait_out(33);
    check("k_100_3_q", quotient, 33);
    check("k_100_3_r", remainder, 1);
    collect();

    // multiplier round trip
    for (int i = 0; i < 1000; i++) begin
      a = SW'($urandom_range(0, 65535));
      b = SW'($urandom_range(1, 65535));
      p = {{(DW-SW){1'b0}}, a} * {{(DW-SW){1'b0}}, b};
      start_op(p, b);
      wait_out(33);
      check("rt_quotient", quotient, {{(DW-SW){1'b0}}, a});
      check("rt_remainder", remainder, 0);
      check("rt_ovf", q_ovf, 0);
      collect();
    end

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
